y86_pipe_stage_reg: RTL and testbench

//  Parametrised Y86 inter-stage pipeline register (F->D, D->E, E->M, M->W) with load, stall and bubble control.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_pipe_stage_reg_if.sv | 44 ++++
 rtl/y86_pipe_stage_reg_sat_counter.sv | 20 ++
 rtl/y86_pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_y86_pipe_stage_reg.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes, register-ID
// sentinel and default datapath widths used by the pipeline registers.
package y86_pkg;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SADR = 3'd2,
        SINS = 3'd3,
        SHLT = 3'd4
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_REG_W  = 4;
    localparam int unsigned DEF_STAT_W = 3;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/y86_pipe_stage_reg_if.sv
// Bundle between the hazard-control unit / upstream stage (master) and a
// Y86 inter-stage pipeline register (slave): control, payload in and out,
// error flag and performance counters.
interface y86_pipe_stage_reg_if
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned STAT_W = DEF_STAT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic              stall;
    logic              bubble;
    logic [STAT_W-1:0] in_stat;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    logic [DATA_W-1:0] in_valC;
    logic [DATA_W-1:0] in_valP;
    logic [REG_W-1:0]  in_rA;
    logic [REG_W-1:0]  in_rB;
    logic [STAT_W-1:0] out_stat;
    logic [3:0]        out_icode;
    logic [3:0]        out_ifun;
    logic [DATA_W-1:0] out_valC;
    logic [DATA_W-1:0] out_valP;
    logic [REG_W-1:0]  out_rA;
    logic [REG_W-1:0]  out_rB;
    logic              ctrl_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall, bubble, in_stat, in_icode, in_ifun, in_valC, in_valP, in_rA, in_rB,
        input  out_stat, out_icode, out_ifun, out_valC, out_valP, out_rA, out_rB,
        input  ctrl_err, stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, bubble, in_stat, in_icode, in_ifun, in_valC, in_valP, in_rA, in_rB,
        output out_stat, out_icode, out_ifun, out_valC, out_valP, out_rA, out_rB,
        output ctrl_err, stall_cnt, bubble_cnt
    );

endinterface

// File: rtl/y86_pipe_stage_reg_sat_counter.sv
// pipe_sat_counter: counts cycles with inc high, sticking at all-ones.
module pipe_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Y86 inter-stage pipeline register with stall (hold), bubble (load NOP)
// and load; stall wins over bubble. ctrl_err is sticky on stall+bubble.
// Optional perf counters enabled by defining PIPE_REG_PERF_EN.
module y86_pipe_stage_reg
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W       = DEF_DATA_W,
    parameter int unsigned       REG_W        = DEF_REG_W,
    parameter int unsigned       STAT_W       = DEF_STAT_W,
    parameter logic [3:0]        BUBBLE_ICODE = INOP,
    parameter logic [STAT_W-1:0] BUBBLE_STAT  = STAT_W'(SAOK),
    parameter logic [REG_W-1:0]  RNONE        = REG_W'(y86_pkg::RNONE),
    parameter int unsigned       CNT_W        = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    y86_pipe_stage_reg_if.slave bus
);

    logic [STAT_W-1:0] stat_q;
    logic [3:0]        icode_q;
    logic [3:0]        ifun_q;
    logic [DATA_W-1:0] valC_q;
    logic [DATA_W-1:0] valP_q;
    logic [REG_W-1:0]  rA_q;
    logic [REG_W-1:0]  rB_q;
    logic              err_q;

    // Payload: hold on stall, NOP on bubble, otherwise capture upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q  <= BUBBLE_STAT;
            icode_q <= BUBBLE_ICODE;
            ifun_q  <= '0;
            valC_q  <= '0;
            valP_q  <= '0;
            rA_q    <= RNONE;
            rB_q    <= RNONE;
        end else if (bus.stall) begin
            stat_q  <= stat_q;
        end else if (bus.bubble) begin
            stat_q  <= BUBBLE_STAT;
            icode_q <= BUBBLE_ICODE;
            ifun_q  <= '0;
            valC_q  <= '0;
            valP_q  <= '0;
            rA_q    <= RNONE;
            rB_q    <= RNONE;
        end else begin
            stat_q  <= bus.in_stat;
            icode_q <= bus.in_icode;
            ifun_q  <= bus.in_ifun;
            valC_q  <= bus.in_valC;
            valP_q  <= bus.in_valP;
            rA_q    <= bus.in_rA;
            rB_q    <= bus.in_rB;
        end
    end

    // Sticky flag for the illegal stall+bubble combination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.stall && bus.bubble) begin
            err_q <= 1'b1;
        end
    end

    assign bus.out_stat  = stat_q;
    assign bus.out_icode = icode_q;
    assign bus.out_ifun  = ifun_q;
    assign bus.out_valC  = valC_q;
    assign bus.out_valP  = valP_q;
    assign bus.out_rA    = rA_q;
    assign bus.out_rB    = rB_q;
    assign bus.ctrl_err  = err_q;

`ifdef PIPE_REG_PERF_EN
    logic bubble_loaded;
    assign bubble_loaded = bus.bubble & ~bus.stall;

    pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.stall),
        .count (bus.stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_loaded),
        .count (bus.bubble_cnt)
    );
`else
    assign bus.stall_cnt  = CNT_W'(0);
    assign bus.bubble_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Scoreboard bench for y86_pipe_stage_reg: each driven cycle pushes the
// expected register contents; they are popped and compared after the edge.
// Counter expectations follow PIPE_REG_PERF_EN.
module tb_y86_pipe_stage_reg;

    localparam int unsigned CW = 4;
`ifdef PIPE_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [2:0]    stat;
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic [63:0]   valC;
        logic [63:0]   valP;
        logic [3:0]    rA;
        logic [3:0]    rB;
        logic          err;
        logic [CW-1:0] scnt;
        logic [CW-1:0] bcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    y86_pipe_stage_reg_if #(.DATA_W(64), .REG_W(4), .STAT_W(3), .CNT_W(CW)) bus ();

    y86_pipe_stage_reg #(
        .DATA_W(64), .REG_W(4), .STAT_W(3),
        .BUBBLE_ICODE(4'h1), .BUBBLE_STAT(3'd1), .RNONE(4'hF), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t m;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t reset_val();
        exp_t r;
        r.stat = 3'd1; r.icode = 4'h1; r.ifun = 4'h0;
        r.valC = '0; r.valP = '0; r.rA = 4'hF; r.rB = 4'hF;
        r.err = 1'b0; r.scnt = '0; r.bcnt = '0;
        return r;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_stat"},  64'(bus.out_stat),  64'(e.stat));
        check({tag, "_icode"}, 64'(bus.out_icode), 64'(e.icode));
        check({tag, "_ifun"},  64'(bus.out_ifun),  64'(e.ifun));
        check({tag, "_valC"},  bus.out_valC,       e.valC);
        check({tag, "_valP"},  bus.out_valP,       e.valP);
        check({tag, "_rA"},    64'(bus.out_rA),    64'(e.rA));
        check({tag, "_rB"},    64'(bus.out_rB),    64'(e.rB));
        check({tag, "_err"},   64'(bus.ctrl_err),  64'(e.err));
        check({tag, "_scnt"},  64'(bus.stall_cnt), PERF ? 64'(e.scnt) : 64'd0);
        check({tag, "_bcnt"},  64'(bus.bubble_cnt), PERF ? 64'(e.bcnt) : 64'd0);
    endtask

    // One clock: drive at negedge, advance the model, compare after the edge.
    task automatic step(input string tag, input logic st, input logic bb,
                        input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] valC, input logic [63:0] valP,
                        input logic [3:0] rA, input logic [3:0] rB);
        exp_t b;
        @(negedge clk);
        bus.stall = st; bus.bubble = bb;
        bus.in_stat = stat; bus.in_icode = icode; bus.in_ifun = ifun;
        bus.in_valC = valC; bus.in_valP = valP; bus.in_rA = rA; bus.in_rB = rB;
        if (st) begin
            if (bb) m.err = 1'b1;
            if (m.scnt != '1) m.scnt = m.scnt + 1'b1;
        end else if (bb) begin
            b = reset_val();
            m.stat = b.stat; m.icode = b.icode; m.ifun = b.ifun;
            m.valC = b.valC; m.valP = b.valP; m.rA = b.rA; m.rB = b.rB;
            if (m.bcnt != '1) m.bcnt = m.bcnt + 1'b1;
        end else begin
            m.stat = stat; m.icode = icode; m.ifun = ifun;
            m.valC = valC; m.valP = valP; m.rA = rA; m.rB = rB;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic load_rand(input string tag);
        step(tag, 1'b0, 1'b0, 3'($urandom_range(1, 4)), 4'($urandom), 4'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 4'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.stall = 0; bus.bubble = 0;
        bus.in_stat = 0; bus.in_icode = 0; bus.in_ifun = 0;
        bus.in_valC = 0; bus.in_valP = 0; bus.in_rA = 0; bus.in_rB = 0;

        // Reset state, observed while reset is held
        m = reset_val();
        #12;
        exp_q.push_back(m);
        compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load, then confirm no combinational path from in_* to out_*
        step("load", 0, 0, 3'd1, 4'h3, 4'h0, 64'h100, 64'hA, 4'hF, 4'h2);
        bus.in_valC = 64'hFFFF_0000_1234_5678;
        #2;
        check("no_comb_path", bus.out_valC, 64'h100);

        // Stall for three edges with a new upstream valC
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 3'd2, 4'h5, 4'h1, 64'hDEAD, 64'hBEEF, 4'h1, 4'h1);

        // Bubble replaces an OPq
        step("load_opq", 0, 0, 3'd1, 4'h6, 4'h1, 64'h55, 64'h20, 4'h3, 4'h4);
        step("bubble", 0, 1, 3'd3, 4'h7, 4'h2, 64'h77, 64'h88, 4'h5, 4'h6);

        // Conflict holds outputs and latches ctrl_err through normal loads
        step("load_pre", 0, 0, 3'd4, 4'h9, 4'h0, 64'h1234, 64'h5678, 4'h7, 4'h8);
        step("conflict", 1, 1, 3'd2, 4'h2, 4'h3, 64'hAAAA, 64'hBBBB, 4'h9, 4'hA);
        for (int i = 0; i < 5; i++) load_rand("post_conflict");

        // Stall long enough to saturate a 4-bit counter
        for (int i = 0; i < 20; i++)
            step("sat_stall", 1, 0, 3'd1, 4'h4, 4'h0, 64'(i), 64'(i), 4'h0, 4'h0);

        // Mixed random control
        for (int i = 0; i < 30; i++)
            step("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 3'($urandom_range(1, 4)), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 4'($urandom));

        // Asynchronous reset mid-operation, checked before any edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m = reset_val();
        exp_q.push_back(m);
        compare("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_bubble", 0, 1, 3'd2, 4'h8, 4'h1, 64'h9, 64'h9, 4'h1, 4'h2);
        step("post_reset_load", 0, 0, 3'd4, 4'h0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0001, 4'hE, 4'h0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
